// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive buffer
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef struct packed {
        logic                   perr;
        logic [UART_DATA_W-1:0] data;
    } uart_rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH-entry register array, synchronous write, asynchronous read
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           i_we,
    input  logic [AW-1:0]  i_waddr,
    input  uart_rx_entry_t i_wdata,
    input  logic [AW-1:0]  i_raddr,
    output uart_rx_entry_t o_rdata
);

    // Contents are intentionally left unreset; the pointers define validity.
    uart_rx_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - FWFT receive FIFO with sticky overflow behind the UART rx path
// Optional macro UART_RX_BUFFER_DROP_PERR_EN: discard parity-errored bytes and flag perr_seen.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = 12,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] rxdout,
    input  logic                   rxvalid,
    input  logic                   parity_err,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   rd_perr,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [AW:0]            level,
    output logic                   almost_full,
    output logic                   overflow,
`ifdef UART_RX_BUFFER_DROP_PERR_EN
    output logic                   perr_seen,
`endif
    input  logic                   ovf_clr
);

    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_TH);

    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic           r_overflow;
    logic [AW:0]    w_level;
    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic           w_cand;
    logic           w_push;
    logic           w_drop;
    uart_rx_entry_t w_wentry;
    uart_rx_entry_t w_rentry;

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_pop = !w_empty && rd_ready;

`ifdef UART_RX_BUFFER_DROP_PERR_EN
    logic r_perr_seen;

    // Errored bytes never reach the FIFO, so they can neither fill it nor overflow it.
    assign w_cand        = rxvalid && !parity_err;
    assign w_wentry.perr = 1'b0;
    assign rd_perr       = 1'b0;
    assign perr_seen     = r_perr_seen;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perr_seen <= 1'b0;
        end else if (rxvalid && parity_err) begin
            r_perr_seen <= 1'b1;
        end else if (ovf_clr) begin
            r_perr_seen <= 1'b0;
        end
    end
`else
    assign w_cand        = rxvalid;
    assign w_wentry.perr = parity_err;
    assign rd_perr       = w_rentry.perr;
`endif

    assign w_wentry.data = rxdout;

    // A pop frees the slot in the same edge, so a full FIFO still accepts the byte.
    assign w_push = w_cand && (!w_full || w_pop);
    assign w_drop = w_cand && w_full && !w_pop;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push && rst),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (w_wentry),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rentry)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rd_data     = w_rentry.data;
    assign rd_valid    = !w_empty;
    assign level       = w_level;
    assign almost_full = (w_level >= AFULL_LVL);
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - scoreboard bench for uart_rx_buffer
module tb_uart_rx_buffer;

    localparam int DEPTH    = 16;
    localparam int AFULL_TH = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rxdout;
    logic       rxvalid;
    logic       parity_err;
    logic [7:0] rd_data;
    logic       rd_perr;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] level;
    logic       almost_full;
    logic       overflow;
    logic       ovf_clr;
`ifdef UART_RX_BUFFER_DROP_PERR_EN
    logic       perr_seen;
`endif

    uart_rx_buffer #(
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rxdout      (rxdout),
        .rxvalid     (rxvalid),
        .parity_err  (parity_err),
        .rd_data     (rd_data),
        .rd_perr     (rd_perr),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow),
`ifdef UART_RX_BUFFER_DROP_PERR_EN
        .perr_seen   (perr_seen),
`endif
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] sb[$];
    logic       m_ovf = 1'b0;
    logic       m_perr_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic post_check();
        logic [8:0] h;
        chk("level", 32'(level), 32'(sb.size()));
        chk("rd_valid", 32'(rd_valid), 32'(sb.size() != 0));
        chk("almost_full", 32'(almost_full), 32'(sb.size() >= AFULL_TH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef UART_RX_BUFFER_DROP_PERR_EN
        chk("perr_seen", 32'(perr_seen), 32'(m_perr_seen));
`endif
        if (sb.size() != 0) begin
            h = sb[0];
            chk("rd_data", 32'(rd_data), 32'(h[7:0]));
            chk("rd_perr", 32'(rd_perr), 32'(h[8]));
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic pe,
                         input logic rdy, input logic clr);
        bit pop, full, cand;
        full = (sb.size() == DEPTH);
        pop  = (sb.size() != 0) && rdy;
        cand = v;
`ifdef UART_RX_BUFFER_DROP_PERR_EN
        cand = v && !pe;
`endif
        rxvalid    = v;
        rxdout     = d;
        parity_err = pe;
        rd_ready   = rdy;
        ovf_clr    = clr;
        @(posedge clk);
        if (pop) void'(sb.pop_front());
        if (cand && (!full || pop)) sb.push_back({pe, d});
        if (cand && full && !pop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (v && pe) m_perr_seen = 1'b1;
        else if (clr) m_perr_seen = 1'b0;
        @(negedge clk);
        rxvalid  = 1'b0;
        ovf_clr  = 1'b0;
        rd_ready = 1'b0;
        post_check();
    endtask

    task automatic do_reset(input logic v);
        rst     = 1'b0;
        rxvalid = v;
        rxdout  = 8'hEE;
        @(posedge clk);
        sb.delete();
        m_ovf       = 1'b0;
        m_perr_seen = 1'b0;
        @(negedge clk);
        rst     = 1'b1;
        rxvalid = 1'b0;
        post_check();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b0; rxdout = 8'h00; rxvalid = 1'b0; parity_err = 1'b0;
        rd_ready = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        do_reset(1'b0);
        do_reset(1'b0);

        cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);

        cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h66, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        drain();

        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
        drain();

        cycle(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        drain();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
        do_reset(1'b1);
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
